// File: rtl/cc_gen_reg_pkg.sv
// LC-3b shared datapath types and condition-code constants.
// Exports: lc3b_word, lc3b_nzp, CC_N, CC_Z, CC_P.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    localparam lc3b_nzp CC_N = 3'b100;
    localparam lc3b_nzp CC_Z = 3'b010;
    localparam lc3b_nzp CC_P = 3'b001;

endpackage

// File: rtl/cc_gen_reg_nzp_gen.sv
// Combinational N/Z/P generator for a 16-bit result.
// Ports: data (lc3b_word) in, nzp (one-hot lc3b_nzp) out.
module nzp_gen
    import lc3b_types::*;
(
    input  lc3b_word data,
    output lc3b_nzp  nzp
);

    always_comb begin
        nzp = CC_P;
        unique case (1'b1)
            data[15]:          nzp = CC_N;
            (data == 16'h0000): nzp = CC_Z;
            default:           nzp = CC_P;
        endcase
    end

endmodule

// File: rtl/cc_gen_reg.sv
// Condition-code register with forwarding and in-flight writer tracking.
// Ports: clk, reset (sync, high), cc_data, load_cc, cc_claim, cc_flush ->
//        nzp_cc, nzp_fwd, cc_ready, pending, cc_err.
module cc_gen_reg
    import lc3b_types::*;
#(
    parameter int      MAX_INFLIGHT = 3,
    parameter lc3b_nzp RESET_CC     = 3'b010,
    localparam int     PW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  lc3b_word      cc_data,
    input  logic          load_cc,
    input  logic          cc_claim,
    input  logic          cc_flush,
    output lc3b_nzp       nzp_cc,
    output lc3b_nzp       nzp_fwd,
    output logic          cc_ready,
    output logic [PW-1:0] pending,
    output logic          cc_err
);

    localparam logic [PW-1:0] MAX_P = PW'(MAX_INFLIGHT);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    lc3b_nzp gen_nzp;

    nzp_gen u_nzp_gen (
        .data (cc_data),
        .nzp  (gen_nzp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_cc <= RESET_CC;
        end else if (load_cc) begin
            nzp_cc <= gen_nzp;
        end
    end

    // Claim+load together is a retire and an issue in one cycle: net zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            cc_err  <= 1'b0;
        end else if (cc_flush) begin
            pending <= '0;
        end else if (cc_claim && !load_cc) begin
            if (pending == MAX_P) begin
                cc_err <= 1'b1;
            end else begin
                pending <= pending + ONE_P;
            end
        end else if (load_cc && !cc_claim) begin
            if (pending != '0) begin
                pending <= pending - ONE_P;
            end
        end
    end

    assign nzp_fwd = load_cc ? gen_nzp : nzp_cc;

    // Last outstanding writer landing now is consumable through nzp_fwd.
    assign cc_ready = !cc_claim &&
                      ((pending == '0) ||
                       ((pending == ONE_P) && load_cc));

endmodule
